led_ctrl: RTL and testbench
===========================

# led_ctrl

LED command executor sitting directly downstream of the SPI slave on the Zybo Z7-20. It consumes the decoded command, address and payload bytes, keeps a per-LED brightness register (0–100 %) and drives one PWM output per LED. For read commands it builds the 24-bit response frame and holds the slave's transmit enable through the following chip-select window.

## Interface
- `NUM_LEDS`, default 4: number of LED channels; valid addresses are `0..NUM_LEDS-1`.
- `PWM_PRESCALE`, default 1250: sysclk cycles per duty step; 125 MHz / (1250 × 100) gives a 1 kHz PWM.
- `sysclk`, input, 1: system clock (125 MHz). This is the only clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `i_cmd`, input, `CMD_BITS`: command byte from the SPI slave. It reads `CMD_NOP` whenever chip select is deasserted.
- `i_addr`, input, `ADDR_BITS`: LED address byte.
- `i_payload`, input, `PAYLOAD_BITS`: brightness in percent.
- `i_cs`, input, 1: raw SPI chip select, active low. It is synchronised internally with two flops.
- `o_slv_tx_enb`, output, 1: drives the slave's `slv_tx_enb`.
- `o_slv_frame`, output, `MASTER_FRAME_WIDTH`: drives the slave's `i_slv_frame`.
- `o_led`, output, `NUM_LEDS`: PWM outputs, active high.
- `o_err`, output, 1: one-cycle pulse on an unknown command or an out-of-range address.

## Operation
- Frame detect
  - `cmd_vld = (i_cmd != CMD_NOP)` is registered.
  - A rising edge of `cmd_vld` captures `i_cmd`, `i_addr` and `i_payload`.
  - This gives exactly one capture per SPI frame. A frame whose command byte is `CMD_NOP` is ignored.
- Command FSM: `IDLE` → `LATCH` → `EXEC` → `IDLE`.
  - `LATCH` registers the captured bytes.
  - `EXEC` acts on them for one cycle.
- `CMD_WRITE` with a valid address:
  - `target[addr] <= (payload > 100) ? 100 : payload`.
  - A payload of 101–255 is clamped to 100. This is not an error.
- `CMD_READ` with a valid address:
  - `o_slv_frame <= {CMD_READ, addr, target[addr]}`.
  - The TX FSM is armed.
- Any other command, or `addr >= NUM_LEDS`:
  - `o_err` pulses for one cycle.
  - No register changes and the TX FSM is not armed.
- TX FSM: `TX_OFF` → `TX_WAIT_HI` → `TX_ARMED` → `TX_ACTIVE` → `TX_OFF`.
  - `TX_WAIT_HI`: waits for synchronised `cs` to go high, which ends the read-command frame.
  - `TX_ARMED`: waits for `cs` low.
  - `TX_ACTIVE`: waits for `cs` high, then returns to `TX_OFF`.
  - `o_slv_tx_enb` = 1 only in `TX_ARMED` and `TX_ACTIVE`.
  - `o_slv_frame` is held constant from arming until `TX_OFF`, then cleared to 0.
- A new valid read arriving in any TX state reloads `o_slv_frame` and restarts the TX FSM at `TX_WAIT_HI`. A write in any TX state leaves the TX FSM untouched.
- PWM
  - A shared prescaler counts `0..PWM_PRESCALE-1` and produces `tick`.
  - A shared duty counter counts `0..99`, advances on `tick` and wraps to 0.
  - At the wrap (`tick` with duty = 99), every `active[i] <= target[i]`.
  - `o_led[i] <= (duty < active[i])`, registered. An `active` value of 0 is constantly off; 100 is constantly on.
- Readback returns `target`, not `active`.

## Timing
- Reset (asynchronous assert, synchronous deassert through the flops):
  - `o_led`, `o_slv_tx_enb`, `o_slv_frame` and `o_err` all go to 0.
  - `target`, `active`, the prescaler and the duty counter all go to 0.
  - Both FSMs go to `IDLE` / `TX_OFF`.
- Reset mid-frame discards the captured bytes and any pending response.
- Latency: cycle 0 is the first sysclk edge that samples a non-NOP `i_cmd`.
  - The effects of `EXEC` (`target`, `o_err`, `o_slv_frame`, TX FSM = `TX_WAIT_HI`) are visible after edge 3.
- `cs` sees a 2-cycle synchroniser delay on top of the FSM transitions.
- A new `target` reaches the LED at the next PWM period boundary, so the worst case is one full period of 100 × `PWM_PRESCALE` cycles.
- Write and wrap in the same cycle: `active` loads the old `target`, and the new value applies one period later.
- SPI frame spacing is at least 10 sysclk cycles, guaranteed by the master. Back-to-back frames are captured individually because `i_cmd` returns to `CMD_NOP` between frames.

## Structure
- Shared constants live in `params.vh`:
  - `CMD_NOP` = 8'h00, `CMD_WRITE` = 8'h01, `CMD_READ` = 8'h02.
  - `BRIGHT_MAX` = 100.
  - The existing frame, command, address and payload widths.
- The prescaler and duty counter are shared. Their widths are `$clog2(PWM_PRESCALE)` and 7 bits.
- Sub-module `led_pwm_channel`, instantiated `NUM_LEDS` times:
  - Inputs: `target`, `wrap`, `duty`.
  - Holds the `active` shadow register and the registered output.

## Test plan
- Reset, then write LED 2 = 50 (`01 02 32`) → after the next period boundary, `o_led[2]` is high for exactly 50 × 1250 cycles of every 125 000-cycle period; other LEDs stay 0.
- Write LED 1 = 200 (`01 01 C8`), then write LED 0 = 0 (`01 00 00`) → `o_led[1]` is constantly 1 after the boundary; `o_led[0]` is constantly 0; `o_err` stays 0.
- After writing LED 3 = 75, send read `02 03 00` → three cycles after capture, `o_slv_frame` = 24'h02034B and `o_slv_tx_enb` stays 0 until `cs` goes high.
  - `o_slv_tx_enb` then rises and stays high through the entire next `cs`-low window.
  - It drops, and `o_slv_frame` clears to 0, after that window's `cs` rising edge (plus the synchroniser delay).
- Send `05 00 10` and `01 04 10` → each produces a single-cycle `o_err` pulse; `target` and the TX state are unchanged.
- Assert `rst_n` low while `TX_ACTIVE` and LED 0 is at 100 → all outputs are 0 immediately (asynchronously).
  - After release, a read of LED 0 returns 24'h020000.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared constants for the LED command executor: SPI byte widths, command codes
// and the brightness ceiling.
package led_ctrl_pkg;

    localparam int CMD_BITS           = 8;
    localparam int ADDR_BITS          = 8;
    localparam int PAYLOAD_BITS       = 8;
    localparam int MASTER_FRAME_WIDTH = 24;
    localparam int DUTY_BITS          = 7;
    localparam int BRIGHT_MAX         = 100;

    localparam logic [CMD_BITS-1:0] CMD_NOP   = 8'h00;
    localparam logic [CMD_BITS-1:0] CMD_WRITE = 8'h01;
    localparam logic [CMD_BITS-1:0] CMD_READ  = 8'h02;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: shadows target into active at each period wrap and compares
// it against the shared duty counter.
module led_pwm_channel
    import led_ctrl_pkg::*;
(
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic [DUTY_BITS-1:0] target,
    input  logic                 wrap,
    input  logic [DUTY_BITS-1:0] duty,
    output logic                 led
);

    logic [DUTY_BITS-1:0] active;

    // active=100 never loses the compare since duty tops out at 99
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            active <= '0;
            led    <= 1'b0;
        end else begin
            if (wrap) active <= target;
            led <= (duty < active);
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// LED command executor behind the SPI slave: captures one command per frame,
// updates per-LED brightness, builds read responses and drives the PWM outputs.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS     = 4,
    parameter int PWM_PRESCALE = 1250
) (
    input  logic                          sysclk,
    input  logic                          rst_n,
    input  logic [CMD_BITS-1:0]           i_cmd,
    input  logic [ADDR_BITS-1:0]          i_addr,
    input  logic [PAYLOAD_BITS-1:0]       i_payload,
    input  logic                          i_cs,
    output logic                          o_slv_tx_enb,
    output logic [MASTER_FRAME_WIDTH-1:0] o_slv_frame,
    output logic [NUM_LEDS-1:0]           o_led,
    output logic                          o_err
);

    localparam int                   PRESC_W    = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(PWM_PRESCALE - 1);
    localparam logic [ADDR_BITS:0]   ADDR_LIMIT = (ADDR_BITS + 1)'(NUM_LEDS);
    localparam logic [DUTY_BITS-1:0] DUTY_LAST  = DUTY_BITS'(BRIGHT_MAX - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    localparam logic [1:0] TX_OFF     = 2'd0;
    localparam logic [1:0] TX_WAIT_HI = 2'd1;
    localparam logic [1:0] TX_ARMED   = 2'd2;
    localparam logic [1:0] TX_ACTIVE  = 2'd3;

    function automatic logic [DUTY_BITS-1:0] clamp_pct(input logic [PAYLOAD_BITS-1:0] pct);
        if (pct > PAYLOAD_BITS'(BRIGHT_MAX)) return DUTY_BITS'(BRIGHT_MAX);
        return pct[DUTY_BITS-1:0];
    endfunction

    logic                    vld_p0, vld_p1;
    logic [CMD_BITS-1:0]     cmd_p0, cmd_p1, cmd_p2;
    logic [ADDR_BITS-1:0]    addr_p0, addr_p1, addr_p2;
    logic [PAYLOAD_BITS-1:0] pay_p0, pay_p1, pay_p2;
    logic [1:0]              state, tx_state;
    logic                    cs_s1, cs_s2;
    logic [DUTY_BITS-1:0]    target [NUM_LEDS];
    logic [DUTY_BITS-1:0]    rd_val;
    logic [PRESC_W-1:0]      presc;
    logic [DUTY_BITS-1:0]    duty;
    logic                    rise, addr_ok, do_wr, do_rd, do_err, tick, wrap;

    assign rise    = vld_p0 & ~vld_p1;
    assign addr_ok = ({1'b0, addr_p2} < ADDR_LIMIT);
    assign do_wr   = (state == ST_EXEC) && (cmd_p2 == CMD_WRITE) && addr_ok;
    assign do_rd   = (state == ST_EXEC) && (cmd_p2 == CMD_READ) && addr_ok;
    assign do_err  = (state == ST_EXEC) && !(do_wr || do_rd);
    assign tick    = (presc == PRESC_LAST);
    assign wrap    = tick && (duty == DUTY_LAST);
    assign o_slv_tx_enb = tx_state[1];

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            if (addr_p2 == ADDR_BITS'(i)) rd_val = target[i];
    end

    // p0: raw bytes sampled every cycle; p1: frame capture; p2: LATCH copy for EXEC
    always_ff @(posedge sysclk) begin
        cmd_p0  <= i_cmd;
        addr_p0 <= i_addr;
        pay_p0  <= i_payload;
        if (state == ST_IDLE && rise) begin
            cmd_p1  <= cmd_p0;
            addr_p1 <= addr_p0;
            pay_p1  <= pay_p0;
        end
        if (state == ST_LATCH) begin
            cmd_p2  <= cmd_p1;
            addr_p2 <= addr_p1;
            pay_p2  <= pay_p1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            state  <= ST_IDLE;
            o_err  <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) target[i] <= '0;
        end else begin
            vld_p0 <= (i_cmd != CMD_NOP);
            vld_p1 <= vld_p0;
            o_err  <= do_err;
            case (state)
                ST_IDLE:  if (rise) state <= ST_LATCH;
                ST_LATCH: state <= ST_EXEC;
                default:  state <= ST_IDLE;
            endcase
            if (do_wr)
                for (int i = 0; i < NUM_LEDS; i++)
                    if (addr_p2 == ADDR_BITS'(i)) target[i] <= clamp_pct(pay_p2);
        end
    end

    // Response path: a valid read always wins over whatever the TX FSM was doing
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1       <= 1'b1;
            cs_s2       <= 1'b1;
            tx_state    <= TX_OFF;
            o_slv_frame <= '0;
        end else begin
            cs_s1 <= i_cs;
            cs_s2 <= cs_s1;
            if (do_rd) begin
                tx_state    <= TX_WAIT_HI;
                o_slv_frame <= {cmd_p2, addr_p2, 1'b0, rd_val};
            end else begin
                case (tx_state)
                    TX_WAIT_HI: if (cs_s2)  tx_state <= TX_ARMED;
                    TX_ARMED:   if (!cs_s2) tx_state <= TX_ACTIVE;
                    TX_ACTIVE:  if (cs_s2) begin
                        tx_state    <= TX_OFF;
                        o_slv_frame <= '0;
                    end
                    default:    tx_state <= TX_OFF;
                endcase
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            duty  <= '0;
        end else begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
            if (tick) duty <= (duty == DUTY_LAST) ? '0 : duty + DUTY_BITS'(1);
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_pwm_channel u_ch (
            .sysclk (sysclk),
            .rst_n  (rst_n),
            .target (target[g]),
            .wrap   (wrap),
            .duty   (duty),
            .led    (o_led[g])
        );
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: command table, TX window and reset sequences,
// then random frames against a brightness/response model.
module tb_led_ctrl;

    localparam int P      = 3;
    localparam int NL     = 4;
    localparam int PERIOD = 100 * P;

    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [7:0]  i_cmd  = 8'h00;
    logic [7:0]  i_addr = 8'h00;
    logic [7:0]  i_payload = 8'h00;
    logic        i_cs   = 1'b1;
    logic        o_slv_tx_enb;
    logic [23:0] o_slv_frame;
    logic [NL-1:0] o_led;
    logic        o_err;

    led_ctrl #(.NUM_LEDS(NL), .PWM_PRESCALE(P)) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .i_cmd        (i_cmd),
        .i_addr       (i_addr),
        .i_payload    (i_payload),
        .i_cs         (i_cs),
        .o_slv_tx_enb (o_slv_tx_enb),
        .o_slv_frame  (o_slv_frame),
        .o_led        (o_led),
        .o_err        (o_err)
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [7:0]  c;
        logic [7:0]  a;
        logic [7:0]  p;
        logic        e;
        logic [23:0] f;
    } vec_t;

    vec_t vecs [12];
    int   n_chk = 0;
    int   n_pass = 0;
    int   err_seen = 0;
    int   tgt [NL];
    int   led_cnt [NL];

    always @(negedge sysclk) if (o_err) err_seen++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Brightness/response model: what the executor should do with one frame
    task automatic model(input logic [7:0] c, a, p, output logic e, output logic [23:0] f);
        int ai;
        ai = int'(a);
        e = 1'b1;
        f = '0;
        if (c == 8'h00) e = 1'b0;
        else if (ai < NL && c == 8'h01) begin
            tgt[ai] = (int'(p) > 100) ? 100 : int'(p);
            e = 1'b0;
        end else if (ai < NL && c == 8'h02) begin
            f = {c, a, 8'(tgt[ai])};
            e = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] c, a, p, input logic exp_e, input logic [23:0] exp_f);
        int e0;
        @(negedge sysclk);
        e0 = err_seen;
        i_cs = 1'b0; i_cmd = c; i_addr = a; i_payload = p;
        repeat (4) @(posedge sysclk);
        #1;
        if (exp_f != 0) begin
            check("frame_exec", 32'(o_slv_frame), 32'(exp_f));
            check("enb_at_exec", 32'(o_slv_tx_enb), 0);
        end
        repeat (6) @(negedge sysclk);
        if (exp_f != 0) check("enb_before_cs_hi", 32'(o_slv_tx_enb), 0);
        i_cs = 1'b1; i_cmd = 8'h00; i_addr = 8'h00; i_payload = 8'h00;
        repeat (10) @(negedge sysclk);
        check("err_pulses", 32'(err_seen - e0), 32'(exp_e));
        check("frame_after", 32'(o_slv_frame), 32'(exp_f));
        check("enb_after", 32'(o_slv_tx_enb), 32'(exp_f != 0));
    endtask

    task automatic do_cmd(input logic [7:0] c, a, p);
        logic e;
        logic [23:0] f;
        model(c, a, p, e, f);
        send_frame(c, a, p, e, f);
    endtask

    task automatic measure_leds();
        repeat (2 * PERIOD) @(negedge sysclk);
        for (int i = 0; i < NL; i++) led_cnt[i] = 0;
        repeat (PERIOD) begin
            @(negedge sysclk);
            for (int i = 0; i < NL; i++) if (o_led[i]) led_cnt[i]++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        logic [23:0] f;
        int drop;

        vecs[0]  = '{8'h01, 8'h02, 8'h32, 1'b0, 24'h000000};
        vecs[1]  = '{8'h01, 8'h01, 8'hC8, 1'b0, 24'h000000};
        vecs[2]  = '{8'h01, 8'h00, 8'h00, 1'b0, 24'h000000};
        vecs[3]  = '{8'h01, 8'h03, 8'h4B, 1'b0, 24'h000000};
        vecs[4]  = '{8'h02, 8'h03, 8'h00, 1'b0, 24'h02034B};
        vecs[5]  = '{8'h05, 8'h00, 8'h10, 1'b1, 24'h000000};
        vecs[6]  = '{8'h01, 8'h04, 8'h10, 1'b1, 24'h000000};
        vecs[7]  = '{8'h02, 8'h02, 8'h00, 1'b0, 24'h020232};
        vecs[8]  = '{8'h02, 8'h01, 8'h00, 1'b0, 24'h020164};
        vecs[9]  = '{8'h02, 8'h07, 8'h00, 1'b1, 24'h000000};
        vecs[10] = '{8'h02, 8'h00, 8'h00, 1'b0, 24'h020000};
        vecs[11] = '{8'h00, 8'h00, 8'h00, 1'b0, 24'h000000};
        for (int i = 0; i < NL; i++) tgt[i] = 0;

        repeat (3) @(negedge sysclk);
        check("rst_led", 32'(o_led), 0);
        check("rst_enb", 32'(o_slv_tx_enb), 0);
        check("rst_frame", 32'(o_slv_frame), 0);
        check("rst_err", 32'(o_err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);

        for (int i = 0; i < 12; i++) begin
            model(vecs[i].c, vecs[i].a, vecs[i].p, e, f);
            send_frame(vecs[i].c, vecs[i].a, vecs[i].p, vecs[i].e, vecs[i].f);
            if (i == 0) begin
                measure_leds();
                check("led0_first", 32'(led_cnt[0]), 0);
                check("led1_first", 32'(led_cnt[1]), 0);
                check("led2_first", 32'(led_cnt[2]), 32'(50 * P));
                check("led3_first", 32'(led_cnt[3]), 0);
            end
        end
        measure_leds();
        check("led0_table", 32'(led_cnt[0]), 0);
        check("led1_table", 32'(led_cnt[1]), 32'(100 * P));
        check("led2_table", 32'(led_cnt[2]), 32'(50 * P));
        check("led3_table", 32'(led_cnt[3]), 32'(75 * P));

        // Read LED 3 then clock the response window out explicitly
        send_frame(8'h02, 8'h03, 8'h00, 1'b0, 24'h02034B);
        @(negedge sysclk);
        i_cs = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge sysclk);
            #1;
            check("enb_window", 32'(o_slv_tx_enb), 1);
            check("frame_window", 32'(o_slv_frame), 32'h02034B);
        end
        @(negedge sysclk);
        i_cs = 1'b1;
        drop = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge sysclk);
            #1;
            if (!o_slv_tx_enb && drop == 0) drop = k;
        end
        check("enb_drop_cycle", 32'(drop), 3);
        check("frame_cleared", 32'(o_slv_frame), 0);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] c;
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4) c = 8'h01;
            else if (r < 7) c = 8'h02;
            else c = 8'($urandom_range(3, 255));
            do_cmd(c, 8'($urandom_range(0, 5)), 8'($urandom_range(0, 255)));
        end
        measure_leds();
        for (int i = 0; i < NL; i++) check("led_random", 32'(led_cnt[i]), 32'(tgt[i] * P));

        // Reset while the response is being clocked out and LED 0 is fully on
        do_cmd(8'h01, 8'h00, 8'h64);
        repeat (2 * PERIOD) @(negedge sysclk);
        check("led0_full_on", 32'(o_led[0]), 1);
        do_cmd(8'h02, 8'h00, 8'h00);
        @(negedge sysclk);
        i_cs = 1'b0;
        repeat (5) @(negedge sysclk);
        check("enb_active_pre_rst", 32'(o_slv_tx_enb), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(o_led), 0);
        check("async_rst_enb", 32'(o_slv_tx_enb), 0);
        check("async_rst_frame", 32'(o_slv_frame), 0);
        check("async_rst_err", 32'(o_err), 0);
        i_cs = 1'b1;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        for (int i = 0; i < NL; i++) tgt[i] = 0;
        repeat (2) @(negedge sysclk);
        send_frame(8'h02, 8'h00, 8'h00, 1'b0, 24'h020000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
